// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, DBIT data bits LSB first, optional parity, stop.
// Timed by the shared 16x oversample tick; tx is registered from next-state values.
module uart_tx #(
   parameter int DBIT       = 8,
   parameter int SB_TICK    = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_tick,
   input  logic            tx_start,
   input  logic [DBIT-1:0] din,
   output logic            tx,
   output logic            tx_busy,
   output logic            tx_done_tick
);

   localparam int SMAX = (SB_TICK > 16) ? SB_TICK - 1 : 15;
   localparam int SW   = $clog2(SMAX + 1);
   localparam int NW   = $clog2(DBIT);
   localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
   localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

   typedef enum logic [2:0] {
      st_idle,
      st_start,
      st_data,
      st_parity,
      st_stop
   } state_t;

   state_t          state_reg, state_next;
   logic [SW-1:0]   s_reg, s_next;
   logic [NW-1:0]   n_reg, n_next;
   logic [DBIT-1:0] b_reg, b_next;
   logic            p_reg, p_next;
   logic            tx_reg, tx_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= st_idle;
         s_reg     <= '0;
         n_reg     <= '0;
         b_reg     <= '0;
         p_reg     <= 1'b0;
         tx_reg    <= 1'b1;
      end else begin
         state_reg <= state_next;
         s_reg     <= s_next;
         n_reg     <= n_next;
         b_reg     <= b_next;
         p_reg     <= p_next;
         tx_reg    <= tx_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      s_next       = s_reg;
      n_next       = n_reg;
      b_next       = b_reg;
      p_next       = p_reg;
      tx_done_tick = 1'b0;
      case (state_reg)
         st_idle: begin
            // a tick arriving with the request is not counted toward the start bit
            if (tx_start) begin
               b_next     = din;
               p_next     = (PARITY_ODD != 0);
               s_next     = '0;
               state_next = st_start;
            end
         end
         st_start: begin
            if (s_tick) begin
               if (s_reg == S_BIT_LAST) begin
                  s_next     = '0;
                  n_next     = '0;
                  state_next = st_data;
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
         st_data: begin
            if (s_tick) begin
               if (s_reg == S_BIT_LAST) begin
                  s_next = '0;
                  b_next = b_reg >> 1;
                  p_next = p_reg ^ b_reg[0];
                  if (n_reg == N_LAST) begin
                     state_next = (PARITY_EN != 0) ? st_parity : st_stop;
                  end else begin
                     n_next = n_reg + 1'b1;
                  end
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
         st_parity: begin
            if (s_tick) begin
               if (s_reg == S_BIT_LAST) begin
                  s_next     = '0;
                  state_next = st_stop;
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
         st_stop: begin
            if (s_tick) begin
               if (s_reg == S_STOP_LAST) begin
                  state_next   = st_idle;
                  tx_done_tick = 1'b1;
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
         default: state_next = st_idle;
      endcase

      // line level follows the state being entered, so it switches on the transition edge
      case (state_next)
         st_start:  tx_next = 1'b0;
         st_data:   tx_next = b_next[0];
         st_parity: tx_next = p_next;
         default:   tx_next = 1'b1;
      endcase
   end

   assign tx      = tx_reg;
   assign tx_busy = (state_reg != st_idle);

endmodule
